// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: ASCII codes, FSM states and
// the bit-period derivation.
package uart_pkg;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, tick marks the last cycle of a
// bit and pre_tick the cycle before it.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clr,
   output logic tick,
   output logic pre_tick
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] cnt;

   // Wrapping at the last cycle restarts the count at every bit boundary.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt <= '0;
      end else if (clr || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick     = (cnt == LAST);
   assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter for 5-bit character codes: hex digits or a CR/LF
// terminator, with a completion pulse for the upstream formatter.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       load,
   input  logic [4:0] data,
   output logic       tx_stop,
   output logic       txd,
   output logic       tx_busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

   tx_state_t  state;
   logic [7:0] shift;
   logic [2:0] bit_idx;
   logic       crlf;
   logic       tick;
   logic       pre_tick;

   function automatic logic [7:0] to_ascii(input logic [3:0] nib);
      if (nib < 4'd10) return ASCII_0 + {4'b0000, nib};
      else             return ASCII_A + {4'b0000, nib} - 8'd10;
   endfunction

   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk      (clk),
      .n_rst    (n_rst),
      .clr      (state == S_IDLE),
      .tick     (tick),
      .pre_tick (pre_tick)
   );

   // Outputs are set one cycle ahead of the bit they describe, so tx_stop is
   // raised on pre_tick to land in the final stop-bit cycle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= S_IDLE;
         shift   <= 8'h00;
         bit_idx <= 3'd0;
         crlf    <= 1'b0;
         txd     <= 1'b1;
         tx_busy <= 1'b0;
         tx_stop <= 1'b0;
      end else begin
         tx_stop <= 1'b0;
         case (state)
            S_IDLE: begin
               txd     <= 1'b1;
               tx_busy <= 1'b0;
               if (load) begin
                  shift   <= data[4] ? ASCII_CR : to_ascii(data[3:0]);
                  crlf    <= data[4];
                  state   <= S_START;
                  txd     <= 1'b0;
                  tx_busy <= 1'b1;
               end
            end
            S_START: begin
               if (tick) begin
                  state   <= S_DATA;
                  bit_idx <= 3'd0;
                  txd     <= shift[0];
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                     txd   <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shift[1];
                     shift   <= {1'b0, shift[7:1]};
                  end
               end
            end
            S_STOP: begin
               if (pre_tick && !crlf) tx_stop <= 1'b1;
               if (tick) begin
                  if (crlf) begin
                     crlf  <= 1'b0;
                     shift <= ASCII_LF;
                     state <= S_START;
                     txd   <= 1'b0;
                  end else begin
                     state   <= S_IDLE;
                     tx_busy <= 1'b0;
                  end
               end
            end
            default: begin
               state   <= S_IDLE;
               txd     <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 10 clocks per bit, comparing the line
// against frames built from the character table.
module tb_uart_tx;

   localparam int CPB = 10;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       load = 1'b0;
   logic [4:0] data = 5'h00;
   logic       tx_stop;
   logic       txd;
   logic       tx_busy;

   int checks = 0;
   int errors = 0;

   uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .load    (load),
      .data    (data),
      .tx_stop (tx_stop),
      .txd     (txd),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      string digits;
      digits = "0123456789ABCDEF";
      return digits[int'(nib)];
   endfunction

   // Sends one code and checks the whole line waveform, busy and stop pulse,
   // then the idle cycle that follows. Entered at a negedge with the DUT idle.
   task automatic run_frame(input logic [4:0] d, input bit disturb, input string name);
      logic [7:0]   chars[$];
      logic         line_bits[$];
      logic [199:0] obs_txd, exp_txd, obs_busy, exp_busy, obs_stop, exp_stop;
      int           n;
      if (d[4]) begin
         chars.push_back(8'h0D);
         chars.push_back(8'h0A);
      end else begin
         chars.push_back(hex_char(d[3:0]));
      end
      foreach (chars[c]) begin
         line_bits.push_back(1'b0);
         for (int b = 0; b < 8; b++) line_bits.push_back(chars[c][b]);
         line_bits.push_back(1'b1);
      end
      n = line_bits.size() * CPB;
      obs_txd = '0; exp_txd = '0; obs_busy = '0; exp_busy = '0;
      obs_stop = '0; exp_stop = '0;
      for (int i = 0; i < n; i++) begin
         exp_txd[i]  = line_bits[i / CPB];
         exp_busy[i] = 1'b1;
      end
      exp_stop[n-1] = 1'b1;

      load = 1'b1;
      data = d;
      @(posedge clk);
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         obs_txd[i-1]  = txd;
         obs_busy[i-1] = tx_busy;
         obs_stop[i-1] = tx_stop;
         if (disturb) begin
            if (i == 35) begin data = 5'h03; load = 1'b0; end
            if (i == 57) load = 1'b1;
            if (i == 73) load = 1'b0;
            if (i == 80) begin load = 1'b1; data = 5'h1F; end
         end
         if (i == n) load = 1'b0;
      end

      checks++;
      if (obs_txd !== exp_txd) begin
         errors++;
         $display("[TB] FAIL %s_txd: got %h expected %h", name, obs_txd, exp_txd);
      end
      checks++;
      if (obs_busy !== exp_busy) begin
         errors++;
         $display("[TB] FAIL %s_busy: got %h expected %h", name, obs_busy, exp_busy);
      end
      checks++;
      if (obs_stop !== exp_stop) begin
         errors++;
         $display("[TB] FAIL %s_stop: got %h expected %h", name, obs_stop, exp_stop);
      end

      @(negedge clk);
      checks++;
      if ({txd, tx_busy, tx_stop} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL %s_idle: got txd/busy/stop=%b expected 100",
                  name, {txd, tx_busy, tx_stop});
      end
   endtask

   task automatic test_reset();
      int bad;
      bad = 0;
      n_rst = 1'b0;
      load  = 1'b1;
      data  = 5'h05;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ({txd, tx_busy, tx_stop} !== 3'b100) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL reset_hold: %0d cycles with txd/busy/stop != 100, expected 0", bad);
      end
      n_rst = 1'b1;
      run_frame(5'h05, 1'b0, "after_reset");
   endtask

   task automatic test_hex_letter();
      run_frame(5'h0A, 1'b0, "hex_letter");
   endtask

   task automatic test_back_to_back();
      run_frame(5'h07, 1'b0, "hex_digit");
      run_frame(5'h0F, 1'b0, "hex_digit_next");
   endtask

   task automatic test_terminator();
      run_frame(5'h1B, 1'b0, "terminator");
   endtask

   task automatic test_busy_ignore();
      run_frame(5'h0C, 1'b1, "busy_ignore");
   endtask

   task automatic test_random();
      logic [4:0] d;
      for (int k = 0; k < 6; k++) begin
         d = 5'($urandom_range(0, 31));
         $display("[TB] random code %h", d);
         run_frame(d, 1'b0, "random");
      end
   endtask

   task automatic test_abort();
      int bad;
      bad = 0;
      load = 1'b1;
      data = 5'h00;
      @(posedge clk);
      for (int i = 1; i <= 45; i++) @(negedge clk);
      checks++;
      if ({txd, tx_busy} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL abort_pre: got txd/busy=%b expected 01", {txd, tx_busy});
      end
      n_rst = 1'b0;
      load  = 1'b0;
      #1;
      checks++;
      if ({txd, tx_busy, tx_stop} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL abort_async: got txd/busy/stop=%b expected 100",
                  {txd, tx_busy, tx_stop});
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if ({txd, tx_busy, tx_stop} !== 3'b100) bad++;
      end
      n_rst = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if ({txd, tx_busy, tx_stop} !== 3'b100) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL abort_no_resume: %0d cycles with txd/busy/stop != 100, expected 0", bad);
      end
      run_frame(5'h0E, 1'b0, "after_abort");
   endtask

   initial begin
      test_reset();
      test_hex_letter();
      test_back_to_back();
      test_terminator();
      test_busy_ignore();
      test_random();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
